// File: rtl/qcw_adc_reader.sv
// Serial ADC frame reader: generates CS/SCLK and checks the framing bits of each 16-bit frame.
// Publishes the 10-bit sample, or a reject pulse when the frame is bad.
module qcw_adc_reader #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned QUIET_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    input  logic       adc_sdata,
    output logic [9:0] adc_dout,
    output logic       sample_valid,
    output logic       frame_err
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned DOUT_W  = 10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_QUIET = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(FRAME_W - 1);
    // Mid-scale code: downstream abs-current reads zero, so no false overcurrent trip.
    localparam logic [DOUT_W-1:0] DOUT_RST   = DOUT_W'(512);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic               phase_q, phase_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]   quiet_q, quiet_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic [DOUT_W-1:0]  dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [FRAME_W-1:0] frame_shift;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        quiet_d     = quiet_q;
        shreg_d     = shreg_q;
        dout_d      = dout_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        frame_shift = {shreg_q[FRAME_W-2:0], adc_sdata};

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_QUIET;
                end
            end
            S_QUIET: begin
                if (quiet_q == QUIET_LAST) begin
                    state_d = S_SHIFT;
                end else begin
                    quiet_d = quiet_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    phase_d = ~phase_q;
                    // Sample on the last cycle of the high phase, far from the ADC launch edge.
                    if (phase_q) begin
                        shreg_d = frame_shift;
                        if (bit_q == BIT_LAST) begin
                            state_d = S_LATCH;
                            if (frame_shift[15:13] == 3'b000 && frame_shift[2:0] == 3'b000) begin
                                dout_d  = frame_shift[12:3];
                                valid_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = enable ? S_QUIET : S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            div_d   = '0;
            phase_d = 1'b0;
            bit_d   = '0;
            quiet_d = '0;
        end

        cs_n_d = (state_d != S_SHIFT);
        sclk_d = (state_d != S_SHIFT) | phase_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            quiet_q <= '0;
            shreg_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            dout_q  <= DOUT_RST;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            quiet_q <= quiet_d;
            shreg_q <= shreg_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign adc_dout     = dout_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_qcw_adc_reader.sv
// Bench for qcw_adc_reader: default instance plus a CLK_DIV=1/QUIET_CYCLES=1 instance,
// each driven by a behavioural ADC and checked against a frame-level reference model.
module tb_qcw_adc_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [2];
    logic       en    [2];
    logic       cs_n  [2];
    logic       sclk  [2];
    logic       sdata [2] = '{1'b0, 1'b0};
    logic       sv    [2];
    logic       fe    [2];
    logic [9:0] dout  [2];

    qcw_adc_reader dut_a (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]),
        .adc_sdata(sdata[0]), .adc_dout(dout[0]), .sample_valid(sv[0]), .frame_err(fe[0])
    );

    qcw_adc_reader #(.CLK_DIV(1), .QUIET_CYCLES(1)) dut_b (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]),
        .adc_sdata(sdata[1]), .adc_dout(dout[1]), .sample_valid(sv[1]), .frame_err(fe[1])
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    logic [15:0] next_word [2];
    logic [15:0] word_cur  [2];
    int          bit_idx   [2];
    int          falls     [2];
    int          toggle_bad[2];
    logic        prev_cs   [2] = '{1'b1, 1'b1};
    logic        prev_sclk [2] = '{1'b1, 1'b1};
    int          ref_dout  [2];
    int          last_t    [2];

    // ADC model and pin monitor: launches the next bit after every SCLK fall inside CS low.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (prev_cs[i] && !cs_n[i]) begin
                falls[i]      = 0;
                toggle_bad[i] = 0;
                word_cur[i]   = next_word[i];
                bit_idx[i]    = 0;
            end else if (!prev_cs[i] && !cs_n[i] && sclk[i] == prev_sclk[i]) begin
                toggle_bad[i]++;
            end
            if (prev_sclk[i] && !sclk[i] && !cs_n[i]) begin
                falls[i]++;
                if (bit_idx[i] < 16) sdata[i] = word_cur[i][15 - bit_idx[i]];
                bit_idx[i]++;
            end
            if (sv[i] || fe[i]) begin
                chk("pulse_exclusive", 32'(sv[i] & fe[i]), 32'd0);
                chk("pulse_pins_idle", 32'({cs_n[i], sclk[i]}), 32'd3);
            end
            prev_cs[i]   = cs_n[i];
            prev_sclk[i] = sclk[i];
        end
    end

    task automatic wait_pulse(input int i, output logic v, output logic e, output int t);
        v = 1'b0;
        e = 1'b0;
        t = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            if (sv[i] || fe[i]) begin
                v = sv[i];
                e = fe[i];
                t = cyc;
                return;
            end
        end
        chk("pulse_timeout", 32'd0, 32'd1);
    endtask

    // One frame through the reference model: good framing bits publish [12:3], else hold.
    task automatic run_frame(input int i, input logic [15:0] w, input int per,
                             output logic v, output logic e);
        int   t;
        logic good;
        next_word[i] = w;
        wait_pulse(i, v, e, t);
        good = (w[15:13] == 3'b000) && (w[2:0] == 3'b000);
        if (good) ref_dout[i] = int'(w[12:3]);
        chk("sample_valid", 32'(v), 32'(good));
        chk("frame_err", 32'(e), 32'(!good));
        chk("adc_dout", 32'(dout[i]), 32'(ref_dout[i]));
        chk("sclk_falls", 32'(falls[i]), 32'd16);
        if (i == 1) chk("sclk_toggle", 32'(toggle_bad[i]), 32'd0);
        if (last_t[i] >= 0 && t >= 0) chk("frame_period", 32'(t - last_t[i]), 32'(per));
        last_t[i] = t;
    endtask

    task automatic cs_latency(input int i, input int exp);
        int n;
        n = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            #1;
            if (!cs_n[i]) begin
                n = k;
                break;
            end
        end
        chk("cs_fall_latency", 32'(n), 32'(exp));
    endtask

    task automatic wait_fall(input int i, input int cnt);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            if (!cs_n[i] && falls[i] == cnt) return;
        end
        chk("wait_fall_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [15:0] word;
        logic        exp_valid;
        logic [9:0]  exp_dout;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic        v, e;
        logic [15:0] w;
        int          bad;

        tbl[0] = '{16'h1528, 1'b1, 10'h2A5};
        tbl[1] = '{16'h1000, 1'b1, 10'h200};
        tbl[2] = '{16'h5FF8, 1'b0, 10'h200};
        tbl[3] = '{16'h0AA9, 1'b0, 10'h200};
        tbl[4] = '{16'h8558, 1'b0, 10'h200};
        tbl[5] = '{16'h0000, 1'b1, 10'h000};
        tbl[6] = '{16'h1FF8, 1'b1, 10'h3FF};

        for (int i = 0; i < 2; i++) begin
            rst[i]       = 1'b1;
            en[i]        = 1'b0;
            next_word[i] = 16'h0000;
            ref_dout[i]  = 512;
            last_t[i]    = -1;
        end

        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs_n", 32'(cs_n[i]), 32'd1);
            chk("rst_sclk", 32'(sclk[i]), 32'd1);
            chk("rst_dout", 32'(dout[i]), 32'd512);
            chk("rst_valid", 32'(sv[i]), 32'd0);
            chk("rst_err", 32'(fe[i]), 32'd0);
        end

        // Default instance: table frames then random frames, enable held high.
        en[0]        = 1'b1;
        next_word[0] = tbl[0].word;
        rst[0]       = 1'b0;
        cs_latency(0, 5);
        for (int k = 0; k < 7; k++) begin
            run_frame(0, tbl[k].word, 69, v, e);
            chk("tbl_valid", 32'(v), 32'(tbl[k].exp_valid));
            chk("tbl_dout", 32'(dout[0]), 32'(tbl[k].exp_dout));
        end
        for (int k = 0; k < 20; k++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 1) w = w & 16'h1FF8;
            run_frame(0, w, 69, v, e);
        end

        // enable dropped at the 5th SCLK: frame finishes, then the bus stays idle.
        next_word[0] = 16'h0D48;
        wait_fall(0, 5);
        en[0] = 1'b0;
        run_frame(0, 16'h0D48, 69, v, e);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            #1;
            if (!cs_n[0] || !sclk[0] || sv[0] || fe[0]) bad++;
        end
        chk("idle_after_disable", 32'(bad), 32'd0);
        chk("idle_dout_hold", 32'(dout[0]), 32'h1A9);
        last_t[0] = -1;

        // Reset at the 8th SCLK: pins released at once, partial frame discarded.
        en[0]        = 1'b1;
        next_word[0] = 16'h1528;
        wait_fall(0, 8);
        rst[0] = 1'b1;
        #1;
        chk("async_rst_cs_n", 32'(cs_n[0]), 32'd1);
        chk("async_rst_sclk", 32'(sclk[0]), 32'd1);
        chk("async_rst_dout", 32'(dout[0]), 32'd512);
        ref_dout[0] = 512;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hold_valid", 32'(sv[0] | fe[0]), 32'd0);
        next_word[0] = 16'h1528;
        rst[0]       = 1'b0;
        cs_latency(0, 5);
        run_frame(0, 16'h1528, 69, v, e);
        run_frame(0, 16'h1000, 69, v, e);

        // Fast instance: single-cycle SCLK phases, single quiet cycle.
        en[1]        = 1'b1;
        next_word[1] = 16'h0000;
        rst[1]       = 1'b0;
        cs_latency(1, 2);
        run_frame(1, 16'h0000, 34, v, e);
        chk("fast_dout_zero", 32'(dout[1]), 32'h000);
        run_frame(1, 16'h1FF8, 34, v, e);
        chk("fast_dout_full", 32'(dout[1]), 32'h3FF);
        for (int k = 0; k < 6; k++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 1) w = w & 16'h1FF8;
            run_frame(1, w, 34, v, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
